// File: rtl/input_control_pkg.sv
// Shared encodings and sizing helpers for the input_control consumers.
// Pure declarations; no logic, no latency, no flow control.
package input_control_pkg;

  localparam logic [1:0] RELEASED   = 2'd0;
  localparam logic [1:0] PRESS_PEND = 2'd1;
  localparam logic [1:0] PRESSED    = 2'd2;
  localparam logic [1:0] REL_PEND   = 2'd3;

  localparam int STAB_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_RELEASED   = RELEASED,
    ST_PRESS_PEND = PRESS_PEND,
    ST_PRESSED    = PRESSED,
    ST_REL_PEND   = REL_PEND
  } db_state_t;

  // A zero hold threshold still needs a 1-bit counter so the saturate compare is legal.
  function automatic int hold_cnt_width(input int hold_samples);
    return (hold_samples < 1) ? 1 : $clog2(hold_samples + 1);
  endfunction

endpackage

// File: rtl/tick_edge.sv
// Rising-edge detector on the divided slow clock; tick is combinational from slow_clk, one clk wide.
// No backpressure: every slow_clk rising edge yields exactly one tick.
module tick_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic slow_clk,
  output logic tick
);

  logic slow_q;

  // Reset high so a slow_clk already high at reset release does not tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) slow_q <= 1'b1;
    else        slow_q <= slow_clk;
  end

  assign tick = slow_clk & ~slow_q;

endmodule

// File: rtl/btn_debounce.sv
// Button debouncer: 2-flop sync, slow-tick sampling, registered press/release/hold pulses one clk after the tick.
// No backpressure: pulses are fire-and-forget single clk cycles.
module btn_debounce
  import input_control_pkg::*;
#(
  parameter int STABLE_SAMPLES = 4,
  parameter int HOLD_SAMPLES   = 100,
  parameter bit ACTIVE_LOW     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic slow_clk,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_hold
);

  localparam int HOLD_W = hold_cnt_width(HOLD_SAMPLES);
  localparam logic [STAB_CNT_W-1:0] STAB_TGT = STAB_CNT_W'(STABLE_SAMPLES);
  localparam logic [HOLD_W-1:0]     HOLD_TGT = HOLD_W'(HOLD_SAMPLES);
  localparam logic                  RAW_IDLE = 1'(ACTIVE_LOW);

  if (STABLE_SAMPLES < 1 || STABLE_SAMPLES > 15) begin : g_bad_stable
    $error("btn_debounce: STABLE_SAMPLES must be in 1..15");
  end

  logic sync1, sync2, s;
  logic tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= RAW_IDLE;
      sync2 <= RAW_IDLE;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  assign s = sync2 ^ RAW_IDLE;

  tick_edge u_tick_edge (
    .clk      (clk),
    .rst_n    (rst_n),
    .slow_clk (slow_clk),
    .tick     (tick)
  );

  db_state_t               state, state_nxt;
  logic [STAB_CNT_W-1:0]   stab_cnt, stab_nxt, stab_inc;
  logic [HOLD_W-1:0]       hold_cnt, hold_nxt, hold_inc;
  logic                    press_nxt, release_nxt, hold_pulse_nxt, level_nxt;

  assign stab_inc = stab_cnt + 1'b1;
  assign hold_inc = hold_cnt + 1'b1;

  always_comb begin
    state_nxt      = state;
    stab_nxt       = stab_cnt;
    hold_nxt       = hold_cnt;
    press_nxt      = 1'b0;
    release_nxt    = 1'b0;
    hold_pulse_nxt = 1'b0;

    if (tick) begin
      unique case (state)
        ST_RELEASED: begin
          if (s) begin
            if (STAB_TGT == 4'd1) begin
              state_nxt = ST_PRESSED;
              stab_nxt  = '0;
              hold_nxt  = '0;
              press_nxt = 1'b1;
            end else begin
              state_nxt = ST_PRESS_PEND;
              stab_nxt  = 4'd1;
            end
          end
        end
        ST_PRESS_PEND: begin
          if (!s) begin
            state_nxt = ST_RELEASED;
            stab_nxt  = '0;
          end else if (stab_inc == STAB_TGT) begin
            state_nxt = ST_PRESSED;
            stab_nxt  = '0;
            hold_nxt  = '0;
            press_nxt = 1'b1;
          end else begin
            stab_nxt  = stab_inc;
          end
        end
        ST_PRESSED: begin
          // hold_cnt saturates at HOLD_TGT, so the pulse can only fire once per press.
          if (s) begin
            if (hold_cnt != HOLD_TGT) begin
              hold_nxt       = hold_inc;
              hold_pulse_nxt = (hold_inc == HOLD_TGT);
            end
          end else if (STAB_TGT == 4'd1) begin
            state_nxt   = ST_RELEASED;
            stab_nxt    = '0;
            hold_nxt    = '0;
            release_nxt = 1'b1;
          end else begin
            state_nxt = ST_REL_PEND;
            stab_nxt  = 4'd1;
          end
        end
        ST_REL_PEND: begin
          if (s) begin
            state_nxt = ST_PRESSED;
            stab_nxt  = '0;
          end else if (stab_inc == STAB_TGT) begin
            state_nxt   = ST_RELEASED;
            stab_nxt    = '0;
            hold_nxt    = '0;
            release_nxt = 1'b1;
          end else begin
            stab_nxt = stab_inc;
          end
        end
      endcase
    end

    level_nxt = (state_nxt == ST_PRESSED) || (state_nxt == ST_REL_PEND);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_RELEASED;
      stab_cnt    <= '0;
      hold_cnt    <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      btn_hold    <= 1'b0;
    end else begin
      state       <= state_nxt;
      stab_cnt    <= stab_nxt;
      hold_cnt    <= hold_nxt;
      btn_level   <= level_nxt;
      btn_press   <= press_nxt;
      btn_release <= release_nxt;
      btn_hold    <= hold_pulse_nxt;
    end
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Randomised and directed bench for btn_debounce against a run-length reference model.
// Slow clock is clk/10, so one sample tick every 10 clk cycles.
module tb_btn_debounce;

  localparam int STABLE = 4;
  localparam int HOLD   = 8;

  logic clk = 1'b0, rst_n = 1'b1, slow_clk = 1'b0, btn_raw = 1'b0;
  logic btn_level, btn_press, btn_release, btn_hold;
  int   checks = 0, errors = 0;
  int   div = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (div == 4) begin
      div      <= 0;
      slow_clk <= ~slow_clk;
    end else begin
      div <= div + 1;
    end
  end

  btn_debounce #(.STABLE_SAMPLES(STABLE), .HOLD_SAMPLES(HOLD), .ACTIVE_LOW(1'b0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .slow_clk    (slow_clk),
    .btn_raw     (btn_raw),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_hold    (btn_hold)
  );

  // Reference: a level commits once the run of identical samples opposite to it reaches STABLE;
  // hold counts samples that are high and follow a high sample while committed pressed.
  logic m_d1, m_d2, m_slow_prev, m_level, m_press, m_release, m_hold, last_s, s_use, prev_s, tk;
  int   run_len, hold_n;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_d1 = 0; m_d2 = 0; m_slow_prev = 1; m_level = 0;
      m_press = 0; m_release = 0; m_hold = 0;
      last_s = 0; run_len = 0; hold_n = 0;
    end else begin
      s_use = m_d2; m_d2 = m_d1; m_d1 = btn_raw;
      tk = slow_clk && !m_slow_prev; m_slow_prev = slow_clk;
      m_press = 0; m_release = 0; m_hold = 0;
      if (tk) begin
        prev_s = last_s;
        run_len = (s_use == last_s) ? run_len + 1 : 1;
        last_s = s_use;
        if (s_use != m_level && run_len >= STABLE) begin
          m_level = s_use;
          if (s_use) begin m_press = 1; hold_n = 0; end
          else begin m_release = 1; hold_n = 0; end
        end else if (m_level && s_use && prev_s && hold_n < HOLD) begin
          hold_n = hold_n + 1;
          if (hold_n == HOLD) m_hold = 1;
        end
      end
    end
  end

  int   cyc = 0, mism = 0, viol = 0;
  int   n_press = 0, n_release = 0, n_hold = 0, mn_press = 0, mn_release = 0, mn_hold = 0;
  int   press_cyc = -1, hold_cyc = -1, mpress_cyc = -1, rise_cyc = -1;
  logic lvl_prev = 1'b0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (btn_level !== m_level || btn_press !== m_press || btn_release !== m_release || btn_hold !== m_hold)
      mism = mism + 1;
    if (btn_press === 1'b1)   begin n_press = n_press + 1; press_cyc = cyc; end
    if (btn_release === 1'b1) n_release = n_release + 1;
    if (btn_hold === 1'b1)    begin n_hold = n_hold + 1; hold_cyc = cyc; end
    if (m_press)   begin mn_press = mn_press + 1; mpress_cyc = cyc; end
    if (m_release) mn_release = mn_release + 1;
    if (m_hold)    mn_hold = mn_hold + 1;
    if (btn_press === 1'b1 && btn_release === 1'b1) viol = viol + 1;
    if (btn_hold === 1'b1 && btn_level !== 1'b1) viol = viol + 1;
    if (btn_level === 1'b1 && lvl_prev !== 1'b1) rise_cyc = cyc;
    lvl_prev = btn_level;
  end

  task automatic run(input logic val, input int ncyc);
    btn_raw = val;
    repeat (ncyc) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    int mm0, p0, r0, h0;
    #2 rst_n = 1'b0;
    run(1'b0, 50);
    checks++;
    if ({btn_level, btn_press, btn_release, btn_hold} !== 4'b0000) begin
      errors++; $display("FAIL reset_outputs got %b expected 0000", {btn_level, btn_press, btn_release, btn_hold});
    end
    mm0 = mism; p0 = n_press; r0 = n_release; h0 = n_hold;
    rst_n = 1'b1;
    run(1'b0, 60);
    checks++;
    if (n_press - p0 + n_release - r0 + n_hold - h0 !== 0) begin
      errors++; $display("FAIL reset_no_pulse got %0d pulses expected 0", n_press - p0 + n_release - r0 + n_hold - h0);
    end
    checks++;
    if (mism - mm0 !== 0) begin errors++; $display("FAIL reset_model got %0d diverging cycles expected 0", mism - mm0); end
  endtask

  task automatic test_press();
    int mm0 = mism, p0 = n_press, r0 = n_release;
    run(1'b1, 65);
    checks++;
    if (n_press - p0 !== 1) begin errors++; $display("FAIL press_count got %0d expected 1", n_press - p0); end
    checks++;
    if (btn_level !== 1'b1) begin errors++; $display("FAIL press_level got %b expected 1", btn_level); end
    checks++;
    if (press_cyc !== rise_cyc) begin errors++; $display("FAIL press_level_align got press %0d level %0d expected equal", press_cyc, rise_cyc); end
    checks++;
    if (press_cyc !== mpress_cyc) begin errors++; $display("FAIL press_timing got cycle %0d expected %0d", press_cyc, mpress_cyc); end
    run(1'b0, 60);
    checks++;
    if (n_release - r0 !== 1 || btn_level !== 1'b0) begin
      errors++; $display("FAIL press_release got %0d releases level %b expected 1 and 0", n_release - r0, btn_level);
    end
    checks++;
    if (mism - mm0 !== 0) begin errors++; $display("FAIL press_model got %0d diverging cycles expected 0", mism - mm0); end
  endtask

  task automatic test_bounce();
    int mm0 = mism, p0 = n_press, c0;
    run(1'b1, 20);
    run(1'b0, 10);
    c0 = cyc;
    checks++;
    if (n_press - p0 !== 0) begin errors++; $display("FAIL bounce_early got %0d presses expected 0", n_press - p0); end
    run(1'b1, 50);
    checks++;
    if (n_press - p0 !== 1) begin errors++; $display("FAIL bounce_count got %0d expected 1", n_press - p0); end
    checks++;
    if (press_cyc < c0 + 32) begin errors++; $display("FAIL bounce_timing got cycle %0d expected >= %0d", press_cyc, c0 + 32); end
    run(1'b0, 60);
    checks++;
    if (mism - mm0 !== 0) begin errors++; $display("FAIL bounce_model got %0d diverging cycles expected 0", mism - mm0); end
  endtask

  task automatic test_hold();
    int mm0 = mism, p0 = n_press, h0 = n_hold, r0 = n_release;
    run(1'b1, 220);
    checks++;
    if (n_press - p0 !== 1 || n_hold - h0 !== 1) begin
      errors++; $display("FAIL hold_count got press %0d hold %0d expected 1 and 1", n_press - p0, n_hold - h0);
    end
    checks++;
    if (hold_cyc - press_cyc !== HOLD * 10) begin
      errors++; $display("FAIL hold_delay got %0d cycles expected %0d", hold_cyc - press_cyc, HOLD * 10);
    end
    run(1'b0, 60);
    checks++;
    if (n_release - r0 !== 1 || btn_level !== 1'b0) begin
      errors++; $display("FAIL hold_release got %0d releases level %b expected 1 and 0", n_release - r0, btn_level);
    end
    checks++;
    if (mism - mm0 !== 0) begin errors++; $display("FAIL hold_model got %0d diverging cycles expected 0", mism - mm0); end
  endtask

  task automatic test_glitch();
    int mm0 = mism, h0 = n_hold, r0 = n_release, g_end;
    run(1'b1, 110);
    run(1'b0, 20);
    g_end = cyc;
    run(1'b1, 100);
    checks++;
    if (n_release - r0 !== 0 || btn_level !== 1'b1) begin
      errors++; $display("FAIL glitch_release got %0d releases level %b expected 0 and 1", n_release - r0, btn_level);
    end
    checks++;
    if (n_hold - h0 !== 1 || hold_cyc - g_end >= 50) begin
      errors++; $display("FAIL glitch_hold got %0d holds at +%0d cycles expected 1 within 50", n_hold - h0, hold_cyc - g_end);
    end
    run(1'b0, 60);
    checks++;
    if (mism - mm0 !== 0) begin errors++; $display("FAIL glitch_model got %0d diverging cycles expected 0", mism - mm0); end
  endtask

  task automatic test_reset_mid();
    int p0, r0, mm0 = mism, rc;
    @(posedge slow_clk);
    @(negedge clk);
    p0 = n_press; r0 = n_release;
    run(1'b1, 35);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({btn_level, btn_press, btn_release, btn_hold} !== 4'b0000 || n_press - p0 !== 0) begin
      errors++; $display("FAIL midreset_outputs got %b presses %0d expected 0000 and 0", {btn_level, btn_press, btn_release, btn_hold}, n_press - p0);
    end
    run(1'b1, 20);
    rst_n = 1'b1;
    rc = cyc;
    run(1'b1, 80);
    checks++;
    if (n_press - p0 !== 1 || press_cyc - rc < 30) begin
      errors++; $display("FAIL midreset_requalify got %0d presses at +%0d expected 1 at >= 30", n_press - p0, press_cyc - rc);
    end
    // Async reset while committed pressed must drop btn_level before any clock edge.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (btn_level !== 1'b0 || n_release - r0 !== 0) begin
      errors++; $display("FAIL midreset_async got level %b releases %0d expected 0 and 0", btn_level, n_release - r0);
    end
    run(1'b0, 5);
    rst_n = 1'b1;
    run(1'b0, 40);
    checks++;
    if (mism - mm0 !== 0) begin errors++; $display("FAIL midreset_model got %0d diverging cycles expected 0", mism - mm0); end
  endtask

  task automatic test_random();
    int mm0 = mism, v0 = viol;
    int p0 = n_press, r0 = n_release, h0 = n_hold, mp0 = mn_press, mr0 = mn_release, mh0 = mn_hold;
    for (int i = 0; i < 60; i++) run(1'($urandom_range(0, 1)), $urandom_range(1, 45));
    run(1'b1, $urandom_range(100, 140));
    run(1'b0, 60);
    checks++;
    if (mism - mm0 !== 0) begin errors++; $display("FAIL random_model got %0d diverging cycles expected 0", mism - mm0); end
    checks++;
    if (n_press - p0 !== mn_press - mp0 || n_release - r0 !== mn_release - mr0 || n_hold - h0 !== mn_hold - mh0) begin
      errors++; $display("FAIL random_counts got %0d/%0d/%0d expected %0d/%0d/%0d", n_press - p0, n_release - r0,
                         n_hold - h0, mn_press - mp0, mn_release - mr0, mn_hold - mh0);
    end
    checks++;
    if (viol - v0 !== 0) begin errors++; $display("FAIL random_exclusive got %0d violations expected 0", viol - v0); end
  endtask

  initial begin
    test_reset();
    test_press();
    test_bounce();
    test_hold();
    test_glitch();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/btn_debounce.md
Name: btn_debounce

Overview:
- Downstream consumer of the frequency divider's slow clock output in input_control.
- Synchronises a raw push-button into the clk domain and samples it only on rising edges of the divided slow clock (for example 100 Hz).
- A level is committed only after STABLE_SAMPLES consecutive equal samples.
- Emits single-clk-cycle press/release/long-hold pulses for the LVL2 control logic.

Parameters:
STABLE_SAMPLES, 4, consecutive equal slow-tick samples needed to commit a level change (legal range 1..15)
HOLD_SAMPLES, 100, slow ticks of continuous press before btn_hold fires; 0 disables hold
ACTIVE_LOW, 0, 1 = btn_raw is pressed when low; normalised internally

Ports:
clk  input  1  system clock (single clock domain)
rst_n  input  1  asynchronous active-low reset
slow_clk  input  1  divided clock from freqdiv, a register in the clk domain; its rising edge is the sample tick
btn_raw  input  1  asynchronous, bouncing button pin
btn_level  output  1  debounced pressed level (1 = pressed)
btn_press  output  1  one-clk pulse on committed press
btn_release  output  1  one-clk pulse on committed release
btn_hold  output  1  one-clk pulse, at most once per press, at HOLD_SAMPLES ticks held

Behaviour:
- Reset (async assert, any state):
  - FSM = RELEASED; all outputs 0; stab_cnt = hold_cnt = 0.
  - Sync flops reset to the inactive raw level (1 if ACTIVE_LOW, else 0).
  - slow_q resets to 1, so no tick occurs on the first cycle after reset.
- Synchroniser:
  - Two flops on btn_raw, then polarity normalisation, giving s.
  - Raw-to-s latency is 2 clk cycles.
- Tick:
  - tick = slow_clk & ~slow_q, where slow_q is slow_clk registered.
  - Exactly one clk cycle per slow_clk rising edge.
  - No tick means no FSM/counter change, whatever s does.
- FSM (states RELEASED, PRESS_PEND, PRESSED, REL_PEND), evaluated only when tick = 1:
  - RELEASED:
    - s=1 -> PRESS_PEND, stab_cnt = 1.
    - If STABLE_SAMPLES = 1, go directly to PRESSED with press.
  - PRESS_PEND:
    - s=1: stab_cnt+1. On reaching STABLE_SAMPLES -> PRESSED, btn_press, hold_cnt = 0.
    - s=0 -> RELEASED, stab_cnt = 0, no pulse.
  - PRESSED:
    - s=1: hold_cnt+1, saturating at HOLD_SAMPLES. btn_hold fires on the tick where hold_cnt becomes HOLD_SAMPLES.
    - s=0 -> REL_PEND, stab_cnt = 1 (direct to RELEASED with release if STABLE_SAMPLES = 1).
  - REL_PEND:
    - s=0: stab_cnt+1. On reaching STABLE_SAMPLES -> RELEASED, btn_release, hold_cnt = 0.
    - s=1 -> PRESSED, stab_cnt = 0. hold_cnt is retained and does not advance on this tick; a glitch does not restart the hold.
- Outputs:
  - All outputs are registered.
  - Pulses are high in the clk cycle after the qualifying tick cycle, for exactly one cycle.
  - btn_level is 1 in PRESSED and REL_PEND. It changes in the same cycle as btn_press / btn_release.
- Widths and counters:
  - stab_cnt is 4 bits.
  - hold_cnt is $clog2(HOLD_SAMPLES+1) bits, minimum 1.
  - No wrap-around: hold_cnt saturates, and btn_hold fires at most once per committed press.
- Simultaneous events:
  - btn_press and btn_release are never both high.
  - btn_hold can only coincide with btn_level = 1.
  - btn_hold never fires in the same cycle as btn_press unless HOLD_SAMPLES = 0, and that setting disables hold entirely.
- Reset mid-operation: everything returns to the reset state with no pulse emitted. A button held through reset release must re-qualify (press reported after STABLE_SAMPLES ticks).
- Parameter guard: elaboration error if STABLE_SAMPLES = 0 or STABLE_SAMPLES > 15.

Decomposition:
- Shared package input_control_pkg:
  - State encoding localparams: RELEASED = 2'd0, PRESS_PEND = 2'd1, PRESSED = 2'd2, REL_PEND = 2'd3.
  - STAB_CNT_W = 4.
- One sub-module, tick_edge: clk, rst_n, slow_clk -> tick. It contains slow_q and the rising-edge detect and is reused by other input_control consumers.
- The synchroniser and FSM stay inline.

Test Plan (STABLE_SAMPLES=4, HOLD_SAMPLES=8, ACTIVE_LOW=0, slow_clk = clk/10 toggle):
1. Reset with btn_raw=0 for 50 cycles -> all outputs 0; no pulses after rst_n rises.
2. btn_raw 0->1 held -> btn_press is one clk pulse one cycle after the 4th tick that samples s=1; btn_level=1 from the same cycle.
3. Bounce: btn_raw high for 2 ticks, low 1 tick, high 4 ticks -> exactly one btn_press, only after the final 4 consecutive high samples.
4. Hold: press held for 20 ticks -> exactly one btn_hold, 8 ticks after press commit; no further hold pulses. Release -> btn_release after 4 low ticks, btn_level=0.
5. Release glitch: while pressed, btn_raw low for 2 ticks then high -> no btn_release; btn_level stays 1; hold count continues.
6. Assert rst_n=0 during PRESS_PEND (stab_cnt=3) with btn_raw still high -> outputs 0 immediately (async). After release, btn_press appears only after 4 fresh ticks.
